internal_bus_arb: RTL and testbench
===================================

INTERNAL_BUS_ARB -- requirements
Module: internal_bus_arb

Interface
REQ-001 Parameter N_CH, default 4: number of requesting channels, range 2..16.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter TO_CYC, default 255: timeout limit in enabled cycles (used only with the timeout macro).
REQ-005 clk  in  1  single clock; all state on posedge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 clk_oe  in  1  clock enable; state advances only when 1.
REQ-008 bus_busy  in  1  external bus occupied; no new grant while 1.
REQ-009 halt_q_in  in  1  arbitration halt; no new grant while 1.
REQ-010 ch_req  in  N_CH  per-channel request, held until its ch_done.
REQ-011 ch_we  in  N_CH  per-channel write(1)/read(0).
REQ-012 ch_addr  in  N_CH*ADDR_W  packed per-channel address.
REQ-013 ch_wdata  in  N_CH*DATA_W  packed per-channel write data.
REQ-014 ch_gnt  out  N_CH  one-hot grant, registered.
REQ-015 ch_done  out  N_CH  one-cycle completion pulse to the granted channel.
REQ-016 ch_err  out  1  timeout flag, qualified by ch_done.
REQ-017 rdata  out  DATA_W  read data, latched at completion.
REQ-018 addr_out / data_out  out  ADDR_W / DATA_W  bus drive; all-zero when idle (OR-combined bus).
REQ-019 read_q / write_q  out  1  bus read/write request.
REQ-020 read_dn / write_dn  in  1  bus read/write complete.
REQ-021 data_in  in  DATA_W  bus read data.

Function
REQ-022 States IDLE, BUSY, DONE; transitions only on cycles with clk_oe=1.
REQ-023 IDLE: any ch_req, bus_busy=0 and halt_q_in=0 -> BUSY; winner chosen round-robin starting at pointer rr_ptr.
REQ-024 On entry to BUSY, the following are registered in the same edge: ch_gnt one-hot, channel address/data/we, addr_out, data_out (writes only, else 0), and read_q or write_q.
REQ-025 BUSY: outputs held stable until read_dn (read) or write_dn (write) sampled 1; the opposite done line is ignored.
REQ-026 On completion -> DONE: read_q/write_q/addr_out/data_out cleared; rdata<=data_in for reads (unchanged for writes); ch_done[winner]=1 for exactly one cycle; rr_ptr<=(winner+1) mod N_CH.
REQ-027 DONE -> IDLE unconditionally; minimum request-to-request gap is one IDLE cycle.
REQ-028 Dropping ch_req during BUSY does not abort; the transaction completes and ch_done still pulses.
REQ-029 bus_busy/halt_q_in rising during BUSY has no effect on the current transaction.
REQ-030 With only one requester, that channel wins regardless of rr_ptr.

Reset
REQ-031 rst=0 immediately forces IDLE, rr_ptr=0, and all outputs (ch_gnt, ch_done, ch_err, rdata, addr_out, data_out, read_q, write_q) to 0, including mid-transaction.

Configuration
REQ-032 Macro INTERNAL_BUS_TIMEOUT_EN defined: a counter runs in BUSY; after TO_CYC enabled cycles without a done, the block goes to DONE with ch_done and ch_err=1 and rdata unchanged.
REQ-033 Macro INTERNAL_BUS_TIMEOUT_EN undefined: BUSY waits indefinitely; ch_err is tied to 0; no counter is synthesised.

Structure
REQ-034 Package internal_bus_pkg holds the state encoding and default width constants.
REQ-035 Sub-module rr_arbiter (combinational: request vector + pointer -> one-hot winner and index) is instantiated once.

Verification
REQ-036 Single read: ch_req=4'b0010, we=0, addr 0x100; read_dn after 3 cycles with data_in=0xDEADBEEF -> gnt=0010, read_q for 4 cycles, ch_done[1] pulse, rdata=0xDEADBEEF.
REQ-037 Fairness: ch_req=4'b1111 held -> grants in the order ch0, ch1, ch2, ch3, ch0.
REQ-038 Gating: bus_busy=1 with ch_req=0001 -> no grant; bus_busy falls -> grant on the next enabled edge.
REQ-039 Reset during BUSY: write in progress, rst low -> write_q, addr_out, and ch_gnt are 0 asynchronously; after release, IDLE with rr_ptr=0.
REQ-040 Timeout (macro on, TO_CYC=8): read with no read_dn -> ch_done and ch_err pulse after 8 cycles, then back to IDLE.
REQ-041 clk_oe=0 for 5 cycles mid-BUSY with read_dn=1 -> no transition until clk_oe=1.

Source files
------------

// File: rtl/internal_bus_pkg.sv
// Shared encoding and default sizing for the internal bus arbiter.
// The arbiter's optional timeout is enabled by defining INTERNAL_BUS_TIMEOUT_EN.
package internal_bus_pkg;

    localparam int unsigned DefNCh   = 4;
    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefToCyc = 255;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } arb_state_e;

    // Index width for a channel count, never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Produces the one-hot grant, its binary index and a valid flag.
module rr_arbiter
    import internal_bus_pkg::*;
#(
    parameter int unsigned N_CH  = DefNCh,
    parameter int unsigned PTR_W = ptr_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    int unsigned cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = (int'(ptr) + k) % N_CH;
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/internal_bus_arb.sv
// Round-robin arbiter granting N_CH channels one at a time onto a shared read/write bus.
// Define INTERNAL_BUS_TIMEOUT_EN to abort a transaction after TO_CYC enabled cycles.
module internal_bus_arb
    import internal_bus_pkg::*;
#(
    parameter int unsigned N_CH   = DefNCh,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned TO_CYC = DefToCyc
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_oe,
    input  logic                     bus_busy,
    input  logic                     halt_q_in,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_we,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_wdata,
    output logic [N_CH-1:0]          ch_gnt,
    output logic [N_CH-1:0]          ch_done,
    output logic                     ch_err,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     read_q,
    output logic                     write_q,
    input  logic                     read_dn,
    input  logic                     write_dn,
    input  logic [DATA_W-1:0]        data_in
);

    localparam int unsigned PTR_W = ptr_width(N_CH);

    if (N_CH < 2 || N_CH > 16 || TO_CYC == 0) begin : g_param_err
        $error("internal_bus_arb: N_CH must be 2..16 and TO_CYC nonzero");
    end

    arb_state_e        state_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  winner_q;
    logic [PTR_W-1:0]  next_ptr;
    logic              we_q;

    logic [N_CH-1:0]   arb_gnt;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_valid;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              bus_done;
    logic              to_hit;

    rr_arbiter #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (ch_req),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_addr  = ch_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata[int'(arb_idx)*DATA_W +: DATA_W];
        sel_we    = ch_we[arb_idx];
    end

    // Only the done line matching the transaction direction is honoured.
    assign bus_done = we_q ? write_dn : read_dn;
    assign next_ptr = (winner_q == PTR_W'(N_CH - 1)) ? '0 : winner_q + 1'b1;

`ifdef INTERNAL_BUS_TIMEOUT_EN
    localparam int unsigned CntW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    logic [CntW-1:0] to_cnt_q;
    logic            err_q;

    assign to_hit = (state_q == StBusy) && !bus_done && (to_cnt_q == CntW'(TO_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else if (clk_oe) begin
            to_cnt_q <= (state_q == StBusy && !bus_done && !to_hit) ? to_cnt_q + 1'b1 : '0;
            err_q    <= to_hit;
        end
    end

    assign ch_err = err_q;
`else
    assign to_hit = 1'b0;
    assign ch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            winner_q <= '0;
            we_q     <= 1'b0;
            ch_gnt   <= '0;
            ch_done  <= '0;
            rdata    <= '0;
            addr_out <= '0;
            data_out <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end else if (clk_oe) begin
            unique case (state_q)
                StIdle: begin
                    if (arb_valid && !bus_busy && !halt_q_in) begin
                        state_q  <= StBusy;
                        ch_gnt   <= arb_gnt;
                        winner_q <= arb_idx;
                        we_q     <= sel_we;
                        addr_out <= sel_addr;
                        data_out <= sel_we ? sel_wdata : '0;
                        read_q   <= !sel_we;
                        write_q  <= sel_we;
                    end
                end
                StBusy: begin
                    if (bus_done || to_hit) begin
                        state_q  <= StDone;
                        ch_gnt   <= '0;
                        ch_done  <= ch_gnt;
                        addr_out <= '0;
                        data_out <= '0;
                        read_q   <= 1'b0;
                        write_q  <= 1'b0;
                        rr_ptr_q <= next_ptr;
                        // A timed-out read leaves the last good rdata in place.
                        if (!we_q && bus_done) begin
                            rdata <= data_in;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ch_done <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_internal_bus_arb.sv
// Transaction-level bench for internal_bus_arb: directed scenarios plus randomized
// round-robin traffic checked against an arithmetic rotation model.
module tb_internal_bus_arb;

    localparam int unsigned NCh = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_oe;
    logic              bus_busy;
    logic              halt_q_in;
    logic [NCh-1:0]    ch_req;
    logic [NCh-1:0]    ch_we;
    logic [NCh*AW-1:0] ch_addr;
    logic [NCh*DW-1:0] ch_wdata;
    logic [NCh-1:0]    ch_gnt;
    logic [NCh-1:0]    ch_done;
    logic              ch_err;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     addr_out;
    logic [DW-1:0]     data_out;
    logic              read_q;
    logic              write_q;
    logic              read_dn;
    logic              write_dn;
    logic [DW-1:0]     data_in;

    int n_tests = 0;
    int n_fail  = 0;
    int ref_ptr = 0;
    logic [DW-1:0] ref_rdata = '0;

    internal_bus_arb #(
        .N_CH   (NCh),
        .ADDR_W (AW),
        .DATA_W (DW),
        .TO_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_oe    (clk_oe),
        .bus_busy  (bus_busy),
        .halt_q_in (halt_q_in),
        .ch_req    (ch_req),
        .ch_we     (ch_we),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_gnt    (ch_gnt),
        .ch_done   (ch_done),
        .ch_err    (ch_err),
        .rdata     (rdata),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .read_q    (read_q),
        .write_q   (write_q),
        .read_dn   (read_dn),
        .write_dn  (write_dn),
        .data_in   (data_in)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rotation rule: first requesting channel at or after the pointer, wrapping.
    function automatic int pick(input logic [NCh-1:0] req, input int ptr);
        for (int k = 0; k < NCh; k++) begin
            if (req[(ptr + k) % NCh]) return (ptr + k) % NCh;
        end
        return -1;
    endfunction

    task automatic randomize_channels();
        for (int i = 0; i < NCh; i++) begin
            ch_we[i]             = 1'($urandom_range(0, 1));
            ch_addr[i*AW +: AW]  = $urandom;
            ch_wdata[i*DW +: DW] = $urandom;
        end
    endtask

    task automatic run_txn(input logic [NCh-1:0] req, input int lat, input int gate);
        int w;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
        ch_req = req;
        for (int g = 0; g < gate; g++) begin
            if ($urandom_range(0, 1) == 1) bus_busy = 1'b1;
            else halt_q_in = 1'b1;
            tick();
            check_eq("gated_no_grant", 64'(ch_gnt), 64'(0));
        end
        bus_busy  = 1'b0;
        halt_q_in = 1'b0;
        tick();
        w  = pick(req, ref_ptr);
        we = ch_we[w];
        a  = ch_addr[w*AW +: AW];
        d  = ch_wdata[w*DW +: DW];
        check_eq("grant", 64'(ch_gnt), 64'(1) << w);
        check_eq("addr_out", 64'(addr_out), 64'(a));
        check_eq("data_out", 64'(data_out), we ? 64'(d) : 64'(0));
        check_eq("read_q", 64'(read_q), 64'(!we));
        check_eq("write_q", 64'(write_q), 64'(we));
        for (int c = 0; c < lat; c++) begin
            read_dn   = we;
            write_dn  = !we;
            bus_busy  = 1'($urandom_range(0, 1));
            halt_q_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) ch_req[w] = 1'b0;
            tick();
            check_eq("busy_hold_gnt", 64'(ch_gnt), 64'(1) << w);
            check_eq("busy_hold_addr", 64'(addr_out), 64'(a));
            check_eq("busy_hold_dir", 64'({read_q, write_q}), 64'({!we, we}));
            check_eq("busy_no_done", 64'(ch_done), 64'(0));
        end
        rd        = $urandom;
        data_in   = rd;
        read_dn   = !we;
        write_dn  = we;
        bus_busy  = 1'b0;
        halt_q_in = 1'b0;
        tick();
        if (!we) ref_rdata = rd;
        ref_ptr = (w + 1) % NCh;
        check_eq("done_pulse", 64'(ch_done), 64'(1) << w);
        check_eq("done_gnt_clr", 64'(ch_gnt), 64'(0));
        check_eq("done_bus_clr", 64'({addr_out, data_out, read_q, write_q}), 64'(0));
        check_eq("done_err", 64'(ch_err), 64'(0));
        check_eq("rdata", 64'(rdata), 64'(ref_rdata));
        read_dn   = 1'b0;
        write_dn  = 1'b0;
        ch_req[w] = 1'b0;
        tick();
        check_eq("done_one_cycle", 64'(ch_done), 64'(0));
    endtask

    initial begin
        int rq_cycles;
        logic [NCh-1:0] rreq;
        rst       = 1'b0;
        clk_oe    = 1'b1;
        bus_busy  = 1'b0;
        halt_q_in = 1'b0;
        ch_req    = '0;
        ch_we     = '0;
        ch_addr   = '0;
        ch_wdata  = '0;
        read_dn   = 1'b0;
        write_dn  = 1'b0;
        data_in   = '0;
        #3;
        check_eq("reset_outputs",
                 64'({ch_gnt, ch_done, ch_err, read_q, write_q}), 64'(0));
        check_eq("reset_bus", 64'(addr_out | data_out | rdata), 64'(0));
        tick();
        rst = 1'b1;
        tick();
        check_eq("idle_no_grant", 64'(ch_gnt), 64'(0));

        // Single read on channel 1 with a three-cycle bus latency.
        randomize_channels();
        ch_we[1]         = 1'b0;
        ch_addr[63:32]   = 32'h100;
        ch_req           = 4'b0010;
        tick();
        check_eq("single_gnt", 64'(ch_gnt), 64'(4'b0010));
        check_eq("single_addr", 64'(addr_out), 64'(32'h100));
        rq_cycles = int'(read_q);
        for (int c = 0; c < 3; c++) begin
            tick();
            rq_cycles += int'(read_q);
        end
        read_dn = 1'b1;
        data_in = 32'hDEADBEEF;
        tick();
        check_eq("single_read_q_cycles", 64'(rq_cycles), 64'(4));
        check_eq("single_done", 64'(ch_done), 64'(4'b0010));
        check_eq("single_rdata", 64'(rdata), 64'(32'hDEADBEEF));
        ref_rdata = 32'hDEADBEEF;
        ref_ptr   = 2;
        read_dn   = 1'b0;
        ch_req    = '0;
        tick();
        check_eq("single_done_clr", 64'(ch_done), 64'(0));

        // Lone requester behind bus_busy/halt, pointer currently past it.
        randomize_channels();
        run_txn(4'b0001, 1, 3);

        // Asynchronous reset in the middle of a write.
        ch_we[2] = 1'b1;
        ch_req   = 4'b0100;
        tick();
        check_eq("pre_reset_write_q", 64'(write_q), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_reset_bus",
                 64'({write_q, ch_gnt, addr_out}), 64'(0));
        ch_req = '0;
        tick();
        rst       = 1'b1;
        ref_ptr   = 0;
        ref_rdata = '0;
        tick();

        // All four requesting continuously: rotation starts at ch0 after reset.
        for (int k = 0; k < 5; k++) begin
            randomize_channels();
            check_eq("fair_order_model", 64'(pick(4'b1111, ref_ptr)), 64'(k % NCh));
            run_txn(4'b1111, k % 3, 0);
        end

        // Clock enable low mid-transaction freezes everything, even with read_dn high.
        randomize_channels();
        ch_we[3] = 1'b0;
        ch_req   = 4'b1000;
        tick();
        check_eq("oe_gnt", 64'(ch_gnt), 64'(4'b1000));
        read_dn = 1'b1;
        data_in = 32'h1234_5678;
        clk_oe  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("oe_frozen", 64'({read_q, ch_done}), 64'({1'b1, 4'b0000}));
        end
        clk_oe = 1'b1;
        tick();
        check_eq("oe_done", 64'(ch_done), 64'(4'b1000));
        check_eq("oe_rdata", 64'(rdata), 64'(32'h1234_5678));
        ref_rdata = 32'h1234_5678;
        ref_ptr   = 0;
        read_dn   = 1'b0;
        ch_req    = '0;
        tick();

        for (int t = 0; t < 40; t++) begin
            randomize_channels();
            rreq = 4'($urandom_range(1, 15));
            run_txn(rreq, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
        end

`ifdef INTERNAL_BUS_TIMEOUT_EN
        randomize_channels();
        ch_we[ref_ptr] = 1'b0;
        ch_req = 4'b1111;
        tick();
        for (int c = 0; c < 7; c++) begin
            tick();
            check_eq("to_waiting", 64'(ch_done), 64'(0));
        end
        tick();
        check_eq("to_done", 64'(ch_done), 64'(1) << ref_ptr);
        check_eq("to_err", 64'(ch_err), 64'(1));
        check_eq("to_rdata_kept", 64'(rdata), 64'(ref_rdata));
        ch_req = '0;
        tick();
        check_eq("to_clear", 64'({ch_done, ch_err}), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
